// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (I) and data (D) with D priority.
// Define MEM_ARB_FAIR_EN to bound consecutive D grants while fetch waits (MAX_D_STREAK).
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_D_STREAK = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                m_req,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_be,
   input  logic                m_gnt,
   input  logic                m_rvalid,
   input  logic [DATA_W-1:0]   m_rdata
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } mreq_t;

   state_t state, state_nxt;
   mreq_t  req_q, req_win;
   logic   own_d;
   logic   win_d;
   logic   grant_i, grant_d;

`ifdef MEM_ARB_FAIR_EN
   localparam logic [3:0] STREAK_LIM = 4'(MAX_D_STREAK);
   logic [3:0] d_streak;

   // Fetch takes the slot once D has won STREAK_LIM times in a row against it.
   assign win_d = d_req && !(i_req && (d_streak == STREAK_LIM));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_streak <= '0;
      end else if (state == IDLE) begin
         if (!i_req || grant_i)
            d_streak <= '0;
         else if (grant_d)
            d_streak <= d_streak + 4'd1;
      end
   end
`else
   logic unused_streak_lim;
   assign unused_streak_lim = ^4'(MAX_D_STREAK);
   assign win_d = d_req;
`endif

   // Grants are combinational; gating with rst_n keeps every output low during reset.
   assign grant_d = rst_n && (state == IDLE) && win_d;
   assign grant_i = rst_n && (state == IDLE) && i_req && !win_d;

   always_comb begin
      req_win = '{we: 1'b0, addr: i_addr, wdata: '0, be: '1};
      if (grant_d)
         req_win = '{we: d_we, addr: d_addr, wdata: d_wdata, be: d_be};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q <= '0;
         own_d <= 1'b0;
      end else if (grant_i || grant_d) begin
         req_q <= req_win;
         own_d <= grant_d;
      end
   end

   always_comb begin
      state_nxt = state;
      i_gnt     = grant_i;
      d_gnt     = grant_d;
      i_rvalid  = 1'b0;
      d_rvalid  = 1'b0;
      i_rdata   = '0;
      d_rdata   = '0;
      m_req     = 1'b0;
      case (state)
         IDLE: begin
            if (grant_i || grant_d)
               state_nxt = ISSUE;
         end
         ISSUE: begin
            m_req = 1'b1;
            if (m_gnt)
               state_nxt = WAIT;
         end
         WAIT: begin
            if (m_rvalid) begin
               state_nxt = IDLE;
               if (own_d) begin
                  d_rvalid = 1'b1;
                  d_rdata  = m_rdata;
               end else begin
                  i_rvalid = 1'b1;
                  i_rdata  = m_rdata;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign m_we    = req_q.we;
   assign m_addr  = req_q.addr;
   assign m_wdata = req_q.wdata;
   assign m_be    = req_q.be;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single-port memory between instruction fetch (I) and the data-memory stage (D, driven by the `mem_d_we`/`mem_d_wdsrc` control path). It accepts one request at a time, issues it to memory with a req/gnt handshake, and routes the response back to its owner. D has priority over I, with an optional anti-starvation limit for fetch. One transaction is outstanding at a time, so the design needs no ID tags.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: data width, a multiple of 8.
- `MAX_D_STREAK`, default 4: consecutive D grants allowed while I waits. Range 1..15. Used only with `MEM_ARB_FAIR_EN`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_req`  in  1  fetch request; held until `i_gnt`.
- `i_addr`  in  ADDR_W  fetch address.
- `i_gnt`  out  1  one-cycle pulse: fetch request captured.
- `i_rvalid`  out  1  one-cycle pulse: `i_rdata` valid.
- `i_rdata`  out  DATA_W  fetch read data.
- `d_req`  in  1  data request; held until `d_gnt`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  write data.
- `d_be`  in  DATA_W/8  byte enables.
- `d_gnt`  out  1  one-cycle pulse: data request captured.
- `d_rvalid`  out  1  one-cycle pulse: read data, or write acknowledge.
- `d_rdata`  out  DATA_W  data read data.
- `m_req`  out  1  memory request; held until `m_gnt`.
- `m_we`, `m_addr`, `m_wdata`, `m_be`  out  1 / ADDR_W / DATA_W / DATA_W/8  registered request fields; stable while `m_req` is high.
- `m_gnt`  in  1  memory accepted the request.
- `m_rvalid`  in  1  response; returned for reads and writes.
- `m_rdata`  in  DATA_W  memory read data.

## Operation
State machine states are IDLE, ISSUE and WAIT.

- **IDLE**
  - If either request is high, choose a winner and pulse its `*_gnt` (combinational, this cycle).
  - Capture the winner's fields into the `m_*` registers. I requests capture `m_we=0` and `m_be` all-ones.
  - Store the owner in `own_d`. Next state is ISSUE.
  - With no request, stay in IDLE.
- **ISSUE**: `m_req=1`. On `m_gnt`, move to WAIT; otherwise stay, holding all fields.
- **WAIT**
  - On `m_rvalid`, pulse the owner's `*_rvalid`, drive its `*_rdata = m_rdata` and move to IDLE.
  - The non-owner `*_rvalid` stays 0.
  - `*_rdata` is 0 whenever the matching `*_rvalid` is 0.
- **Stray responses**: `m_rvalid` outside WAIT is ignored, and `m_gnt` outside ISSUE is ignored.
- **Arbitration**: only I requesting → I wins; only D requesting → D wins; both requesting → D wins, except under the fairness rule in Configuration.
- **Requester obligations**: a requester must not change its fields while its req is high and its gnt has not yet pulsed. After gnt it may drop req or present the next request.

## Timing
- **Reset values**: all outputs are 0 and the state is IDLE.
- **Reset mid-operation**: asynchronous reset at any state aborts the transaction with no response. The memory is reset by the same `rst_n`.
- **Best-case latency**:
  - gnt in cycle 0 (IDLE).
  - `m_req` in cycle 1.
  - With `m_gnt` in cycle 1 and `m_rvalid` in cycle 2, `*_rvalid` is in cycle 2.
  - IDLE is in cycle 3, so the minimum is 3 cycles per transaction.
- **Memory stalls**: each cycle of `m_gnt` low adds one cycle, as does each cycle of `m_rvalid` delay.
- **Simultaneous events**: a request arriving in the same cycle as `m_rvalid` is not arbitrated until the following IDLE cycle.

## Configuration
- **`MEM_ARB_FAIR_EN` defined**
  - Counter `d_streak` (4 bits) increments on each D grant made while `i_req=1`.
  - It clears on any I grant, and on any IDLE cycle with `i_req=0`.
  - When both requests are high and `d_streak == MAX_D_STREAK`, I wins.
  - Reset value is 0.
- **`MEM_ARB_FAIR_EN` undefined**: strict D priority; no counter is built; fetch may starve indefinitely.

## Test plan
- **Reset**: `rst_n=0` mid-WAIT → all outputs 0 in the same cycle. After release, `i_req` with `i_addr=0x100` → `i_gnt` in cycle 0, `m_req`/`m_addr=0x100` in cycle 1.
- **Fetch read**: `m_gnt` in cycle 1, `m_rdata=0xDEADBEEF` with `m_rvalid` in cycle 2 → `i_rvalid=1` and `i_rdata=0xDEADBEEF` in cycle 2; `d_rvalid=0`.
- **Data write with memory backpressure**: `d_we=1`, `d_addr=0x2004`, `d_wdata=0x55AA`, `d_be=4'b0011`, `m_gnt` held low 3 cycles → `m_*` fields stable for 4 cycles of `m_req`, then `d_rvalid` on `m_rvalid`.
- **Collision**: `i_req` and `d_req` high together in IDLE → `d_gnt` only. I is served in the next IDLE if D has dropped.
- **Fairness, `MEM_ARB_FAIR_EN` with `MAX_D_STREAK=2`**: `i_req` and `d_req` held continuously → grant order D, D, I, D, D, I. Without the macro → all D.
- **Stray response**: `m_rvalid` pulsed in IDLE and in ISSUE → no `*_rvalid` and no state change.
